// File: rtl/add_issue_queue.sv
// add_issue_queue: reservation station in front of the ADD execution unit.
// Holds up to DEPTH add uops in a collapsing, age-ordered queue. Entry 0 is
// the oldest. Missing operands are captured from the write-back bus, and each
// cycle the oldest entry with both operands ready is issued into registered
// outputs that drive the ADD unit directly.
module add_issue_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int PW    = 5,
   parameter int TW    = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       freeze_back,
   input  logic                       valid_dispatch,
   input  logic [PW-1:0]              Pw_dispatch,
   input  logic [TW-1:0]              tag_ROB_dispatch,
   input  logic [PW-1:0]              Pa_dispatch,
   input  logic [PW-1:0]              Pb_dispatch,
   input  logic                       readyA_dispatch,
   input  logic                       readyB_dispatch,
   input  logic [DW-1:0]              dataA_dispatch,
   input  logic [DW-1:0]              dataB_dispatch,
   output logic                       ready_dispatch,
   input  logic                       valid_wb,
   input  logic [PW-1:0]              Pw_wb,
   input  logic [DW-1:0]              Result_wb,
   output logic                       valid_add,
   output logic [PW-1:0]              Pw_add,
   output logic [TW-1:0]              tag_ROB_add,
   output logic [DW-1:0]              busA_add,
   output logic [DW-1:0]              busB_add,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic          vld;
      logic [PW-1:0] pw;
      logic [TW-1:0] tag;
      logic [PW-1:0] pa;
      logic [PW-1:0] pb;
      logic          rdya;
      logic          rdyb;
      logic [DW-1:0] da;
      logic [DW-1:0] db;
   } entry_t;

   entry_t        q   [DEPTH];
   entry_t        n_q [DEPTH];
   entry_t        new_entry;
   logic [CW-1:0] n_count;
   logic [CW-1:0] wr_idx;
   logic [IW-1:0] sel;
   logic          found;
   logic          issue;
   logic          accept;
   logic          byp_a;
   logic          byp_b;

   // Slot availability comes from the registered count only, so a slot freed
   // by this cycle's issue is not offered until the next cycle.
   assign ready_dispatch = (count < CW'(DEPTH));
   assign accept         = valid_dispatch && ready_dispatch;
   assign issue          = found && !freeze_back;
   assign wr_idx         = count - CW'(issue);

   // Select the oldest entry whose registered ready bits are both set.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && q[i].vld && q[i].rdya && q[i].rdyb) begin
            found = 1'b1;
            sel   = IW'(i);
         end
      end
   end

   // Build the incoming entry, bypassing a same-cycle write-back match.
   always_comb begin
      byp_a = valid_wb && !readyA_dispatch && (Pa_dispatch == Pw_wb);
      byp_b = valid_wb && !readyB_dispatch && (Pb_dispatch == Pw_wb);
      new_entry      = '0;
      new_entry.vld  = 1'b1;
      new_entry.pw   = Pw_dispatch;
      new_entry.tag  = tag_ROB_dispatch;
      new_entry.pa   = Pa_dispatch;
      new_entry.pb   = Pb_dispatch;
      new_entry.rdya = readyA_dispatch || byp_a;
      new_entry.rdyb = readyB_dispatch || byp_b;
      new_entry.da   = byp_a ? Result_wb : dataA_dispatch;
      new_entry.db   = byp_b ? Result_wb : dataB_dispatch;
   end

   // Next queue contents: wakeup, then collapse over the issued slot, then append.
   always_comb begin
      n_q = q;
      if (valid_wb) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (q[i].vld && !q[i].rdya && (q[i].pa == Pw_wb)) begin
               n_q[i].rdya = 1'b1;
               n_q[i].da   = Result_wb;
            end
            if (q[i].vld && !q[i].rdyb && (q[i].pb == Pw_wb)) begin
               n_q[i].rdyb = 1'b1;
               n_q[i].db   = Result_wb;
            end
         end
      end
      if (issue) begin
         // Ascending order reads slot i+1 before it is overwritten.
         for (int i = 0; i < DEPTH-1; i++) begin
            if (IW'(i) >= sel) n_q[i] = n_q[i+1];
         end
         n_q[DEPTH-1] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (accept && (CW'(i) == wr_idx)) n_q[i] = new_entry;
      end
      n_count = count + CW'(accept) - CW'(issue);
   end

   // Queue storage: reset and flush empty it, otherwise load the next view.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst || flush) begin
         // NOTE: payload is cleared along with the valid bit; at this depth it is cheap and keeps state deterministic.
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         count <= '0;
      end else begin
         q     <= n_q;
         count <= n_count;
      end
   end

   // Issue registers: cleared on reset/flush, held while frozen, else loaded.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_add   <= 1'b0;
         Pw_add      <= '0;
         tag_ROB_add <= '0;
         busA_add    <= '0;
         busB_add    <= '0;
      end else if (!freeze_back) begin
         valid_add <= found;
         if (found) begin
            Pw_add      <= q[sel].pw;
            tag_ROB_add <= q[sel].tag;
            busA_add    <= q[sel].da;
            busB_add    <= q[sel].db;
         end
      end
   end

endmodule

// File: tb/tb_add_issue_queue.sv
// Self-checking bench for add_issue_queue: directed scenarios followed by
// randomized traffic, all compared against an age-ordered queue model.
module tb_add_issue_queue;

   localparam int DEPTH = 4;
   localparam int DW    = 16;
   localparam int PW    = 5;
   localparam int TW    = 5;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst, flush, freeze_back, valid_dispatch;
   logic [PW-1:0] Pw_dispatch, Pa_dispatch, Pb_dispatch, Pw_wb;
   logic [TW-1:0] tag_ROB_dispatch;
   logic          readyA_dispatch, readyB_dispatch, valid_wb;
   logic [DW-1:0] dataA_dispatch, dataB_dispatch, Result_wb;
   logic          ready_dispatch, valid_add;
   logic [PW-1:0] Pw_add;
   logic [TW-1:0] tag_ROB_add;
   logic [DW-1:0] busA_add, busB_add;
   logic [CW-1:0] count;

   add_issue_queue #(.DEPTH(DEPTH), .DW(DW), .PW(PW), .TW(TW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
      .valid_dispatch(valid_dispatch), .Pw_dispatch(Pw_dispatch),
      .tag_ROB_dispatch(tag_ROB_dispatch), .Pa_dispatch(Pa_dispatch),
      .Pb_dispatch(Pb_dispatch), .readyA_dispatch(readyA_dispatch),
      .readyB_dispatch(readyB_dispatch), .dataA_dispatch(dataA_dispatch),
      .dataB_dispatch(dataB_dispatch), .ready_dispatch(ready_dispatch),
      .valid_wb(valid_wb), .Pw_wb(Pw_wb), .Result_wb(Result_wb),
      .valid_add(valid_add), .Pw_add(Pw_add), .tag_ROB_add(tag_ROB_add),
      .busA_add(busA_add), .busB_add(busB_add), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            rst, flush, frz, vd;
      logic [PW-1:0] pw, pa, pb;
      logic [TW-1:0] tag;
      bit            ra, rb;
      logic [DW-1:0] da, db;
      bit            vwb;
      logic [PW-1:0] pwwb;
      logic [DW-1:0] rwb;
   } stim_t;

   typedef struct {
      logic [PW-1:0] pw, pa, pb;
      logic [TW-1:0] tag;
      bit            ra, rb;
      logic [DW-1:0] da, db;
   } uop_t;

   stim_t s;
   uop_t  mq[$];
   bit            e_valid;
   logic [PW-1:0] e_pw;
   logic [TW-1:0] e_tag;
   logic [DW-1:0] e_a, e_b;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference behaviour for one clock edge, written over the uop list.
   task automatic model();
      if (s.rst || s.flush) begin
         mq.delete();
         e_valid = 0; e_pw = '0; e_tag = '0; e_a = '0; e_b = '0;
      end else begin
         bit   room = (mq.size() < DEPTH);
         int   hit  = -1;
         uop_t u;
         if (!s.frz) begin
            foreach (mq[i]) if (hit < 0 && mq[i].ra && mq[i].rb) hit = i;
         end
         if (s.vwb) begin
            foreach (mq[i]) begin
               if (!mq[i].ra && mq[i].pa == s.pwwb) begin mq[i].ra = 1; mq[i].da = s.rwb; end
               if (!mq[i].rb && mq[i].pb == s.pwwb) begin mq[i].rb = 1; mq[i].db = s.rwb; end
            end
         end
         if (!s.frz) begin
            if (hit >= 0) begin
               e_valid = 1; e_pw = mq[hit].pw; e_tag = mq[hit].tag;
               e_a = mq[hit].da; e_b = mq[hit].db;
               mq.delete(hit);
            end else e_valid = 0;
         end
         if (s.vd && room) begin
            u.pw = s.pw; u.tag = s.tag; u.pa = s.pa; u.pb = s.pb;
            u.ra = s.ra; u.rb = s.rb; u.da = s.da; u.db = s.db;
            if (!u.ra && s.vwb && s.pa == s.pwwb) begin u.ra = 1; u.da = s.rwb; end
            if (!u.rb && s.vwb && s.pb == s.pwwb) begin u.rb = 1; u.db = s.rwb; end
            mq.push_back(u);
         end
      end
   endtask

   task automatic compare();
      check("count",   32'(count),          32'(mq.size()));
      check("ready",   32'(ready_dispatch), 32'(mq.size() < DEPTH));
      check("valid",   32'(valid_add),      32'(e_valid));
      check("pw_add",  32'(Pw_add),         32'(e_pw));
      check("tag_add", 32'(tag_ROB_add),    32'(e_tag));
      check("busA",    32'(busA_add),       32'(e_a));
      check("busB",    32'(busB_add),       32'(e_b));
   endtask

   task automatic step();
      rst = s.rst; flush = s.flush; freeze_back = s.frz;
      valid_dispatch = s.vd; Pw_dispatch = s.pw; tag_ROB_dispatch = s.tag;
      Pa_dispatch = s.pa; Pb_dispatch = s.pb;
      readyA_dispatch = s.ra; readyB_dispatch = s.rb;
      dataA_dispatch = s.da; dataB_dispatch = s.db;
      valid_wb = s.vwb; Pw_wb = s.pwwb; Result_wb = s.rwb;
      @(posedge clk);
      model();
      #1;
      compare();
      s = '{default: 0};
   endtask

   task automatic disp(int pw, int tag, int pa, int pb, bit ra, bit rb, int da, int db);
      s.vd = 1; s.pw = PW'(pw); s.tag = TW'(tag); s.pa = PW'(pa); s.pb = PW'(pb);
      s.ra = ra; s.rb = rb; s.da = DW'(da); s.db = DW'(db);
   endtask

   task automatic wb(int p, int r);
      s.vwb = 1; s.pwwb = PW'(p); s.rwb = DW'(r);
   endtask

   task automatic do_reset();
      s.rst = 1; step();
   endtask

   initial begin
      s = '{default: 0};
      e_valid = 0; e_pw = '0; e_tag = '0; e_a = '0; e_b = '0;

      // 1: reset state and basic two-cycle issue latency
      do_reset();
      check("t1_count0", 32'(count), 32'd0);
      check("t1_ready1", 32'(ready_dispatch), 32'd1);
      check("t1_valid0", 32'(valid_add), 32'd0);
      disp(3, 1, 0, 0, 1, 1, 16'h0005, 16'h0007); step();
      check("t1_not_yet", 32'(valid_add), 32'd0);
      step();
      check("t1_valid", 32'(valid_add), 32'd1);
      check("t1_pw",    32'(Pw_add), 32'd3);
      check("t1_tag",   32'(tag_ROB_add), 32'd1);
      check("t1_busA",  32'(busA_add), 32'h0005);
      check("t1_busB",  32'(busB_add), 32'h0007);

      // 2: younger ready uop overtakes a waiting one; wakeup releases the older
      do_reset();
      disp(8, 2, 9, 0, 0, 1, 0, 16'h0002); step();
      disp(2, 3, 0, 0, 1, 1, 16'h0010, 16'h0020); step();
      step();
      check("t2_y_first", 32'(Pw_add), 32'd2);
      wb(9, 16'h1234); step();
      check("t2_gap", 32'(valid_add), 32'd0);
      step();
      check("t2_x_valid", 32'(valid_add), 32'd1);
      check("t2_x_pw",    32'(Pw_add), 32'd8);
      check("t2_x_busA",  32'(busA_add), 32'h1234);

      // 3: full queue refuses dispatch; a middle entry issues and the rest collapse
      do_reset();
      for (int i = 0; i < 4; i++) begin
         disp(10 + i, i, 10 + i, 0, 0, 1, 0, i); step();
      end
      check("t3_full_count", 32'(count), 32'd4);
      check("t3_full_ready", 32'(ready_dispatch), 32'd0);
      disp(14, 9, 0, 0, 1, 1, 1, 1); step();
      check("t3_ignored", 32'(count), 32'd4);
      wb(12, 16'h0C0C); step();
      step();
      check("t3_mid_pw",  32'(Pw_add), 32'd12);
      check("t3_count3",  32'(count), 32'd3);
      wb(13, 16'h0D0D); step();
      step();
      check("t3_shifted", 32'(Pw_add), 32'd13);

      // 4: same-cycle write-back bypass into a dispatching uop
      do_reset();
      disp(4, 4, 7, 0, 0, 1, 0, 16'h0001); wb(7, 16'hBEEF); step();
      step();
      check("t4_valid", 32'(valid_add), 32'd1);
      check("t4_busA",  32'(busA_add), 32'hBEEF);

      // 5: freeze holds outputs while dispatch continues; release issues in age order
      do_reset();
      disp(1, 1, 0, 0, 1, 1, 16'h0011, 16'h0111); step();
      disp(2, 2, 0, 0, 1, 1, 16'h0022, 16'h0222); step();
      s.frz = 1; disp(3, 3, 0, 0, 1, 1, 16'h0033, 16'h0333); step();
      s.frz = 1; step();
      s.frz = 1; step();
      check("t5_hold_pw",  32'(Pw_add), 32'd1);
      check("t5_hold_a",   32'(busA_add), 32'h0011);
      check("t5_count",    32'(count), 32'd2);
      step();
      check("t5_next_b",   32'(Pw_add), 32'd2);
      step();
      check("t5_next_c",   32'(Pw_add), 32'd3);

      // 6: flush clears entries and outputs; stale tags never issue
      do_reset();
      disp(6, 6, 20, 0, 0, 1, 0, 0); step();
      disp(7, 7, 20, 0, 0, 1, 0, 0); step();
      disp(4, 4, 0, 0, 1, 1, 16'h0044, 0); step();
      disp(5, 5, 0, 0, 1, 1, 16'h0055, 0); step();
      check("t6_pre_count", 32'(count), 32'd3);
      check("t6_pre_valid", 32'(valid_add), 32'd1);
      s.flush = 1; step();
      check("t6_count",  32'(count), 32'd0);
      check("t6_valid",  32'(valid_add), 32'd0);
      check("t6_busA",   32'(busA_add), 32'd0);
      wb(20, 16'hFFFF); step();
      step();
      step();
      check("t6_stale", 32'(valid_add), 32'd0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 800; n++) begin
         s.rst   = ($urandom_range(0, 199) == 0);
         s.flush = ($urandom_range(0, 39) == 0);
         s.frz   = ($urandom_range(0, 4) == 0);
         s.vd    = ($urandom_range(0, 2) != 0);
         s.pw    = PW'($urandom);
         s.tag   = TW'($urandom);
         s.pa    = PW'($urandom_range(0, 7));
         s.pb    = PW'($urandom_range(0, 7));
         s.ra    = 1'($urandom_range(0, 1));
         s.rb    = 1'($urandom_range(0, 1));
         s.da    = DW'($urandom);
         s.db    = DW'($urandom);
         s.vwb   = 1'($urandom_range(0, 1));
         s.pwwb  = PW'($urandom_range(0, 7));
         s.rwb   = DW'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
